// File: rtl/operand_fetch_stage.sv
// Operand-fetch stage: 8x16 register file with writeback bypass,
// feeding a valid/ready output register that drives the ALU slices.
module operand_fetch_stage #(
  parameter int DATA_W = 16,
  parameter int NREG   = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  input  logic [DATA_W-1:0] imm,
  input  logic              use_imm,
  input  logic [3:0]        ctrl,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic              out_ainvert,
  output logic              out_binvert,
  output logic              out_cin,
  output logic [1:0]        out_op
);

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              ainv;
    logic              binv;
    logic [1:0]        op;
  } opnd_t;

  logic [DATA_W-1:0] rf [NREG];
  logic              wr_hit;
  logic [DATA_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_t;
  logic              cap;
  opnd_t             nxt;
  opnd_t             q;
  logic              vq;

  assign wr_hit = wb_en && (wb_addr != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++)
        rf[i] <= '0;
    end else if (wr_hit) begin
      rf[wb_addr] <= wb_data;
    end
  end

  // Same-cycle writeback is forwarded so the captured operand sees it.
  always_comb begin
    rd_a = '0;
    unique case (1'b1)
      (rs_addr == '0):                 rd_a = '0;
      (wr_hit && wb_addr == rs_addr):  rd_a = wb_data;
      default:                         rd_a = rf[rs_addr];
    endcase
  end

  always_comb begin
    rd_t = '0;
    unique case (1'b1)
      (rt_addr == '0):                 rd_t = '0;
      (wr_hit && wb_addr == rt_addr):  rd_t = wb_data;
      default:                         rd_t = rf[rt_addr];
    endcase
  end

  always_comb begin
    nxt      = '0;
    nxt.a    = rd_a;
    nxt.b    = use_imm ? imm : rd_t;
    nxt.ainv = ctrl[3];
    nxt.binv = ctrl[2];
    nxt.op   = ctrl[1:0];
  end

  assign in_ready = ~vq | out_ready;
  assign cap      = in_valid & in_ready & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vq <= 1'b0;
    end else if (flush) begin
      vq <= 1'b0;
    end else if (cap) begin
      vq <= 1'b1;
    end else if (out_ready) begin
      vq <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (cap) begin
      q <= nxt;
    end
  end

  assign out_valid   = vq;
  assign out_a       = q.a;
  assign out_b       = q.b;
  assign out_ainvert = q.ainv;
  assign out_binvert = q.binv;
  assign out_cin     = q.binv;
  assign out_op      = q.op;

endmodule
